// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and the double-dabble digit adjust.
package bcd_pkg;

  localparam int unsigned BIN_W  = 16;
  localparam int unsigned BCD_W  = 20;
  localparam int unsigned DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONVERT   = 2'd1,
    WRITEBACK = 2'd2
  } state_t;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    r = a;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_engine.sv
// Iterative binary-to-BCD engine: one add-3/shift step per cycle, 16 steps.
module bcd_dabble_engine
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             eng_done,
  output logic [BCD_W-1:0] bcd
);

  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] adj;
  logic [BIN_W-1:0] shreg;
  logic [4:0]       iter;

  // Digit correction applied to the accumulator before each shift.
  always_comb begin
    adj = dabble_adjust(acc);
  end

  // Load on start, then iterate until the counter runs out; eng_done pulses on the last step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      shreg    <= '0;
      iter     <= '0;
      eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (start) begin
        acc   <= '0;
        shreg <= bin;
        iter  <= 5'(BIN_W);
      end else if (iter != 5'd0) begin
        // Top adjusted bit is always 0 for a 16-bit input, so dropping it is safe.
        acc   <= BCD_W'({adj, shreg[BIN_W-1]});
        shreg <= {shreg[BIN_W-2:0], 1'b0};
        iter  <= iter - 5'd1;
        if (iter == 5'd1) eng_done <= 1'b1;
      end
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one double-dabble engine between CHANNELS requesters.
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       req,
  input  logic [16*CHANNELS-1:0]    req_data,
  output logic [CHANNELS-1:0]       ack,
  output logic [CHANNELS-1:0]       done,
  output logic [20*CHANNELS-1:0]    bcd_out,
  output logic                      busy,
  output logic [2:0]                cur_id
);

  state_t             state;
  logic [2:0]         ptr;
  logic [2:0]         next_ptr;
  logic               hi_found, lo_found, grant_valid;
  logic [2:0]         hi_id, lo_id, grant_id;
  logic [CHANNELS-1:0] grant_oh, cur_oh;
  logic [BIN_W-1:0]   eng_bin;
  logic               eng_start, eng_done;
  logic [BCD_W-1:0]   eng_bcd;

  // Round-robin search: lowest request at or above ptr, else lowest below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (req[j]) begin
        if (j >= 32'(ptr)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_id    = 3'(j);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = 3'(j);
        end
      end
    end
    grant_valid = hi_found | lo_found;
    grant_id    = hi_found ? hi_id : lo_id;
  end

  // One-hot decodes of the grant and current channel, plus the engine data mux.
  always_comb begin
    grant_oh = '0;
    cur_oh   = '0;
    eng_bin  = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (grant_id == 3'(j)) begin
        grant_oh[j] = 1'b1;
        eng_bin     = req_data[16*j +: 16];
      end
      if (cur_id == 3'(j)) cur_oh[j] = 1'b1;
    end
  end

  assign eng_start = grant_valid && (state == IDLE || state == WRITEBACK);
  assign next_ptr  = (32'(cur_id) == 32'(CHANNELS - 1)) ? 3'd0 : cur_id + 3'd1;
  assign busy      = (state != IDLE);

  bcd_dabble_engine u_engine (
    .clk      (clk),
    .reset    (reset),
    .start    (eng_start),
    .bin      (eng_bin),
    .eng_done (eng_done),
    .bcd      (eng_bcd)
  );

  // Arbiter FSM with registered ack/done pulses, pointer and result registers.
  // Result write, done pulse and pointer update happen on the edge that enters
  // WRITEBACK; WRITEBACK itself may grant again so back-to-back work runs every 18 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cur_id  <= '0;
      ack     <= '0;
      done    <= '0;
      bcd_out <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state  <= CONVERT;
            cur_id <= grant_id;
            ack    <= grant_oh;
          end
        end
        CONVERT: begin
          if (eng_done) begin
            state <= WRITEBACK;
            done  <= cur_oh;
            ptr   <= next_ptr;
            for (int unsigned j = 0; j < CHANNELS; j++) begin
              if (cur_oh[j]) bcd_out[20*j +: 20] <= eng_bcd;
            end
          end
        end
        WRITEBACK: begin
          if (grant_valid) begin
            state  <= CONVERT;
            cur_id <= grant_id;
            ack    <= grant_oh;
          end else begin
            state  <= IDLE;
            cur_id <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter against a decimal-arithmetic model.
module tb_bcd_convert_arbiter;

  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [CH-1:0]     req = '0;
  logic [16*CH-1:0]  req_data = '0;
  logic [CH-1:0]     ack, done;
  logic [20*CH-1:0]  bcd_out;
  logic              busy;
  logic [2:0]        cur_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_convert_arbiter #(.CHANNELS(CH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .cur_id   (cur_id)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic do_reset();
    req = '0;
    req_data = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Drive one request and report what happened; caller does the comparisons.
  task automatic convert_one(input int ch, input logic [15:0] val,
                             output int ack_wait, output int done_wait,
                             output logic [19:0] res, output logic [CH-1:0] done_seen);
    req_data[16*ch +: 16] = val;
    req[ch] = 1'b1;
    ack_wait = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack[ch]) begin ack_wait = i; break; end
    end
    req[ch] = 1'b0;
    done_wait = -1;
    res = '0;
    done_seen = '0;
    if (ack_wait > 0) begin
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (done != '0) begin
          done_wait = i;
          res = bcd_out[20*ch +: 20];
          done_seen = done;
          break;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ack, done} !== '0) begin n_bad++; $display("FAIL reset_pulses: got %h required 0", {ack, done}); end
    n_cmp++; if (bcd_out !== '0) begin n_bad++; $display("FAIL reset_bcd: got %h required 0", bcd_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (cur_id !== 3'd0) begin n_bad++; $display("FAIL reset_cur_id: got %0d required 0", cur_id); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_single();
    int dw;
    do_reset();
    req_data[16*2 +: 16] = 16'd1234;
    req[2] = 1'b1;
    @(negedge clk);
    n_cmp++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL single_ack: got %b required 0100", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b required 1", busy); end
    n_cmp++; if (cur_id !== 3'd2) begin n_bad++; $display("FAIL single_cur_id: got %0d required 2", cur_id); end
    req[2] = 1'b0;
    dw = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done != '0) begin dw = i; break; end
    end
    n_cmp++; if (dw !== 17) begin n_bad++; $display("FAIL single_latency: got %0d cycles after ack required 17", dw); end
    n_cmp++; if (done !== 4'b0100) begin n_bad++; $display("FAIL single_done: got %b required 0100", done); end
    n_cmp++; if (bcd_out[59:40] !== 20'h01234) begin n_bad++; $display("FAIL single_result: got %h required 01234", bcd_out[59:40]); end
    n_cmp++; if ({bcd_out[79:60], bcd_out[39:0]} !== '0) begin n_bad++; $display("FAIL single_others: got %h required 0", bcd_out); end
    @(negedge clk);
    n_cmp++; if ({busy, cur_id, done} !== '0) begin n_bad++; $display("FAIL single_return_idle: got busy=%b id=%0d done=%b required all 0", busy, cur_id, done); end
  endtask

  task automatic test_boundaries();
    int unsigned vals [8] = '{0, 9, 10, 65535, 99, 100, 9999, 10000};
    int aw, dw;
    logic [19:0] res;
    logic [CH-1:0] ds;
    do_reset();
    foreach (vals[k]) begin
      convert_one(0, 16'(vals[k]), aw, dw, res, ds);
      n_cmp++; if (res !== ref_bcd(vals[k])) begin n_bad++; $display("FAIL bound_result(%0d): got %h required %h", vals[k], res, ref_bcd(vals[k])); end
      n_cmp++; if (ds !== 4'b0001 || dw !== 17 || aw !== 1) begin n_bad++; $display("FAIL bound_timing(%0d): got ack_wait=%0d done_wait=%0d done=%b required 1/17/0001", vals[k], aw, dw, ds); end
    end
  endtask

  task automatic test_fairness();
    int ndone, cyc, last, overlap, dbl, exp_ch;
    logic [CH-1:0] prev_ack;
    do_reset();
    req_data = {16'd400, 16'd300, 16'd200, 16'd100};
    req = '1;
    ndone = 0; last = 0; overlap = 0; dbl = 0; prev_ack = '0;
    for (cyc = 1; cyc <= 300 && ndone < 8; cyc++) begin
      @(negedge clk);
      if ((ack & done) != '0) overlap++;
      if (ack != '0 && ack === prev_ack) dbl++;
      prev_ack = ack;
      if (done != '0) begin
        exp_ch = ndone % 4;
        n_cmp++; if (done !== 4'(1 << exp_ch)) begin n_bad++; $display("FAIL fair_order[%0d]: got done=%b required channel %0d", ndone, done, exp_ch); end
        n_cmp++; if (bcd_out[20*exp_ch +: 20] !== ref_bcd(100 * (exp_ch + 1))) begin n_bad++; $display("FAIL fair_result[%0d]: got %h required %h", ndone, bcd_out[20*exp_ch +: 20], ref_bcd(100 * (exp_ch + 1))); end
        if (ndone > 0) begin
          n_cmp++; if (cyc - last !== 18) begin n_bad++; $display("FAIL fair_spacing[%0d]: got %0d required 18", ndone, cyc - last); end
        end
        last = cyc;
        ndone++;
        if (ndone == 8) req = '0;
      end
    end
    n_cmp++; if (ndone !== 8) begin n_bad++; $display("FAIL fair_count: got %0d done pulses required 8", ndone); end
    n_cmp++; if (overlap !== 0 || dbl !== 0) begin n_bad++; $display("FAIL fair_pulse_rules: got overlap=%0d double_ack=%0d required 0/0", overlap, dbl); end
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fair_idle: got busy=%b required 0", busy); end
  endtask

  task automatic test_pointer_wrap();
    int aw, dw;
    logic [19:0] res;
    logic [CH-1:0] ds;
    do_reset();
    convert_one(3, 16'd55, aw, dw, res, ds);
    req_data[16*1 +: 16] = 16'd11;
    req_data[16*3 +: 16] = 16'd33;
    req = 4'b1010;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (ack != '0) break; end
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL wrap_first: got ack=%b required 0010", ack); end
    req[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (ack != '0) break; end
    n_cmp++; if (ack !== 4'b1000) begin n_bad++; $display("FAIL wrap_second: got ack=%b required 1000", ack); end
    req = '0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    n_cmp++; if (bcd_out[79:60] !== 20'h00033 || bcd_out[39:20] !== 20'h00011) begin n_bad++; $display("FAIL wrap_results: got ch3=%h ch1=%h required 00033/00011", bcd_out[79:60], bcd_out[39:20]); end
    convert_one(2, 16'd22, aw, dw, res, ds);
    req = 4'b1010;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (ack != '0) break; end
    n_cmp++; if (ack !== 4'b1000) begin n_bad++; $display("FAIL wrap_after_ch2: got ack=%b required 1000", ack); end
    req = '0;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int aw, dw, ndone;
    logic [19:0] res;
    logic [CH-1:0] ds;
    do_reset();
    convert_one(1, 16'd77, aw, dw, res, ds);
    req_data[16*1 +: 16] = 16'd4321;
    req[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (ack[1]) break; end
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    n_cmp++; if ({busy, ack, done, cur_id} !== '0) begin n_bad++; $display("FAIL midreset_ctrl: got busy=%b ack=%b done=%b id=%0d required all 0", busy, ack, done, cur_id); end
    n_cmp++; if (bcd_out !== '0) begin n_bad++; $display("FAIL midreset_bcd: got %h required 0", bcd_out); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (25) begin @(negedge clk); if (done != '0 || ack != '0) ndone++; end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL midreset_no_pulse: got %0d pulses required 0", ndone); end
    convert_one(1, 16'd4321, aw, dw, res, ds);
    n_cmp++; if (res !== 20'h04321 || dw !== 17) begin n_bad++; $display("FAIL midreset_retry: got %h after %0d required 04321 after 17", res, dw); end
  endtask

  task automatic test_data_change();
    int t, t_ack1;
    logic [19:0] r1, r2;
    do_reset();
    req_data[15:0] = 16'd500;
    req[0] = 1'b1;
    t = 0; t_ack1 = -1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); t++; if (ack[0]) begin t_ack1 = t; break; end end
    req_data[15:0] = 16'd777;
    r1 = '1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); t++; if (done[0]) begin r1 = bcd_out[19:0]; break; end end
    n_cmp++; if (r1 !== 20'h00500) begin n_bad++; $display("FAIL change_first: got %h required 00500", r1); end
    for (int i = 0; i < 40; i++) begin @(negedge clk); t++; if (ack[0]) break; end
    n_cmp++; if (t - t_ack1 !== 18) begin n_bad++; $display("FAIL change_regrant: got %0d cycles required 18", t - t_ack1); end
    req[0] = 1'b0;
    r2 = '1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done[0]) begin r2 = bcd_out[19:0]; break; end end
    n_cmp++; if (r2 !== 20'h00777) begin n_bad++; $display("FAIL change_second: got %h required 00777", r2); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [19:0] m [CH];
    logic [20*CH-1:0] expv;
    int aw, dw, ch;
    int unsigned v;
    logic [19:0] res;
    logic [CH-1:0] ds;
    do_reset();
    foreach (m[k]) m[k] = '0;
    for (int n = 0; n < 20; n++) begin
      ch = int'($urandom_range(0, CH - 1));
      v  = $urandom_range(0, 65535);
      convert_one(ch, 16'(v), aw, dw, res, ds);
      m[ch] = ref_bcd(v);
      for (int k = 0; k < CH; k++) expv[20*k +: 20] = m[k];
      n_cmp++; if (res !== m[ch] || dw !== 17) begin n_bad++; $display("FAIL rand_result[%0d] ch%0d val %0d: got %h after %0d required %h after 17", n, ch, v, res, dw, m[ch]); end
      n_cmp++; if (bcd_out !== expv) begin n_bad++; $display("FAIL rand_hold[%0d]: got %h required %h", n, bcd_out, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_fairness();
    test_pointer_wrap();
    test_reset_mid();
    test_data_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
